// File: rtl/temp_sampler.sv
// temp_sampler: periodic temperature capture with sequential double-dabble BCD conversion.
//
// A free-running divider (gated by en) produces a sample tick every SAMPLE_DIV clocks.
// A tick or a sample_now request in IDLE captures temp_raw (saturated to 999) and temp_sign.
// The value is converted to three BCD digits over ten CONV cycles. DONE then publishes the
// current/previous pair together with a one-cycle sample_valid strobe.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  sampling enable (holds divider, ignores triggers)
//   sample_now          immediate sample request (level, sampled each edge)
//   temp_raw[9:0]       unsigned temperature in tenths of a degree
//   temp_sign           mode bit captured alongside temp_raw
//   temp_value_*        current sample BCD digits and mode bit
//   temp_value_*_old    previous sample BCD digits and mode bit
//   sample_valid        one-cycle pulse when a new current/old pair is presented
//   busy                high while a conversion is in flight
//   overrun             sticky: a trigger arrived while busy (cleared by rst only)
module temp_sampler #(
  parameter int unsigned SAMPLE_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sample_now,
  input  logic [9:0] temp_raw,
  input  logic       temp_sign,
  output logic [3:0] temp_value_ones,
  output logic [3:0] temp_value_tens,
  output logic [3:0] temp_value_huns,
  output logic       temp_value_sign,
  output logic [3:0] temp_value_ones_old,
  output logic [3:0] temp_value_tens_old,
  output logic [3:0] temp_value_huns_old,
  output logic       temp_value_sign_old,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun
);

  localparam logic [25:0] DivLast = 26'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      state_q;
  logic [25:0] div_q;
  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [21:0] dd_shift;
  logic [3:0]  iter_q;
  logic        sign_cap_q;
  logic        first_q;
  logic [9:0]  raw_sat;
  logic        tick;
  logic        trigger;

  assign tick    = en && (div_q == DivLast);
  // A coincident tick and sample_now collapse into a single trigger.
  assign trigger = en && (tick || sample_now);
  assign raw_sat = (temp_raw > 10'd999) ? 10'd999 : temp_raw;

  // Divider runs independently of the FSM; it only pauses while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= (div_q == DivLast) ? '0 : div_q + 26'd1;
    end
  end

  // One double-dabble step: add 3 to each digit >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    dd_shift = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= StIdle;
      bin_q               <= '0;
      bcd_q               <= '0;
      iter_q              <= '0;
      sign_cap_q          <= 1'b0;
      first_q             <= 1'b1;
      temp_value_ones     <= '0;
      temp_value_tens     <= '0;
      temp_value_huns     <= '0;
      temp_value_sign     <= 1'b0;
      temp_value_ones_old <= '0;
      temp_value_tens_old <= '0;
      temp_value_huns_old <= '0;
      temp_value_sign_old <= 1'b0;
      sample_valid        <= 1'b0;
      busy                <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (trigger) begin
            bin_q      <= raw_sat;
            sign_cap_q <= temp_sign;
            bcd_q      <= '0;
            iter_q     <= '0;
            busy       <= 1'b1;
            state_q    <= StConv;
          end
        end
        StConv: begin
          if (trigger) overrun <= 1'b1;
          bcd_q <= dd_shift[21:10];
          bin_q <= dd_shift[9:0];
          if (iter_q == 4'd9) begin
            state_q <= StDone;
          end else begin
            iter_q <= iter_q + 4'd1;
          end
        end
        StDone: begin
          if (trigger) overrun <= 1'b1;
          // The first sample after reset also seeds old, so the first delta is zero.
          if (first_q) begin
            temp_value_huns_old <= bcd_q[11:8];
            temp_value_tens_old <= bcd_q[7:4];
            temp_value_ones_old <= bcd_q[3:0];
            temp_value_sign_old <= sign_cap_q;
          end else begin
            temp_value_huns_old <= temp_value_huns;
            temp_value_tens_old <= temp_value_tens;
            temp_value_ones_old <= temp_value_ones;
            temp_value_sign_old <= temp_value_sign;
          end
          temp_value_huns <= bcd_q[11:8];
          temp_value_tens <= bcd_q[7:4];
          temp_value_ones <= bcd_q[3:0];
          temp_value_sign <= sign_cap_q;
          first_q         <= 1'b0;
          sample_valid    <= 1'b1;
          busy            <= 1'b0;
          state_q         <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_sampler.sv
// Self-checking bench for temp_sampler (SAMPLE_DIV = 16).
module tb_temp_sampler;

  localparam int Div = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       sample_now = 1'b0;
  logic [9:0] temp_raw = '0;
  logic       temp_sign = 1'b0;
  logic [3:0] temp_value_ones, temp_value_tens, temp_value_huns;
  logic [3:0] temp_value_ones_old, temp_value_tens_old, temp_value_huns_old;
  logic       temp_value_sign, temp_value_sign_old;
  logic       sample_valid, busy, overrun;
  logic [11:0] cur_d, old_d;

  assign cur_d = {temp_value_huns, temp_value_tens, temp_value_ones};
  assign old_d = {temp_value_huns_old, temp_value_tens_old, temp_value_ones_old};

  temp_sampler #(.SAMPLE_DIV(Div)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .sample_now          (sample_now),
    .temp_raw            (temp_raw),
    .temp_sign           (temp_sign),
    .temp_value_ones     (temp_value_ones),
    .temp_value_tens     (temp_value_tens),
    .temp_value_huns     (temp_value_huns),
    .temp_value_sign     (temp_value_sign),
    .temp_value_ones_old (temp_value_ones_old),
    .temp_value_tens_old (temp_value_tens_old),
    .temp_value_huns_old (temp_value_huns_old),
    .temp_value_sign_old (temp_value_sign_old),
    .sample_valid        (sample_valid),
    .busy                (busy),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;

  // Reference model: sample timing tracked as "edges until publish", value as a plain integer.
  int m_cnt, m_left, m_val, m_cur, m_old;
  bit m_sign, m_cur_s, m_old_s, m_first, m_valid, m_overrun;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_left = 0; m_val = 0; m_cur = 0; m_old = 0;
    m_sign = 0; m_cur_s = 0; m_old_s = 0; m_first = 1; m_valid = 0; m_overrun = 0;
  endtask

  task automatic model_edge();
    bit tick, trig;
    tick = en && (m_cnt == Div - 1);
    trig = en && (tick || sample_now);
    if (en) m_cnt = (m_cnt + 1) % Div;
    m_valid = 0;
    if (m_left > 0) begin
      if (trig) m_overrun = 1;
      m_left--;
      if (m_left == 0) begin
        m_old   = m_first ? m_val : m_cur;
        m_old_s = m_first ? m_sign : m_cur_s;
        m_cur   = m_val;
        m_cur_s = m_sign;
        m_first = 0;
        m_valid = 1;
      end
    end else if (trig) begin
      m_val  = (int'(temp_raw) > 999) ? 999 : int'(temp_raw);
      m_sign = temp_sign;
      m_left = 11;
    end
  endtask

  task automatic compare_all();
    chk("valid", sample_valid, m_valid);
    chk("busy", busy, m_left > 0);
    chk("overrun", overrun, m_overrun);
    chk("cur", cur_d, to_bcd(m_cur));
    chk("cur_sign", temp_value_sign, m_cur_s);
    chk("old", old_d, to_bcd(m_old));
    chk("old_sign", temp_value_sign_old, m_old_s);
  endtask

  // Inputs are set before the call; outputs compared 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    edge_no++;
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    model_reset();
    #1 compare_all();
    chk("rst_cur", cur_d, 0);
    chk("rst_old", old_d, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    #1 rst = 1'b0;
    edge_no = 0;
  endtask

  // Idle until the next trigger edge is 5 edges before a tick (tick then lands mid-CONV).
  task automatic wait_slot(output int nv);
    int guard = 0;
    nv = 0;
    while (!(m_left == 0 && m_cnt == 10) && guard < 64) begin
      cycle();
      guard++;
      if (sample_valid) nv++;
    end
    if (guard >= 64) chk("slot_timeout", guard, 0);
  endtask

  typedef struct {
    int          raw;
    bit          sign;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   got[$];

  initial begin
    int          nv;
    logic [11:0] exp_old;
    bit          exp_old_s;

    tbl = '{'{473, 1'b0, 12'h473}, '{412, 1'b1, 12'h412}, '{1023, 1'b0, 12'h999},
            '{0, 1'b0, 12'h000}, '{999, 1'b1, 12'h999}, '{1000, 1'b0, 12'h999},
            '{5, 1'b0, 12'h005}, '{860, 1'b1, 12'h860}};

    model_reset();
    cycle();
    cycle();
    chk("reset_cur", cur_d, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    edge_no = 0;

    // Free-running ticks with an 8-edge en drop (edges 44..51).
    temp_raw = 10'd400;
    for (int i = 0; i < 90; i++) begin
      en = !(edge_no >= 43 && edge_no < 51);
      cycle();
      if (sample_valid) got.push_back(edge_no);
    end
    en = 1'b1;
    chk("period_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("period_0", got[0], 27);
      chk("period_1", got[1], 43);
      chk("period_2", got[2], 67);
      chk("period_3", got[3], 83);
    end
    chk("period_value", cur_d, 12'h400);

    // Table of samples via sample_now; the first one after reset seeds old as well.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_slot(nv);
      temp_raw   = 10'(tbl[i].raw);
      temp_sign  = tbl[i].sign;
      sample_now = 1'b1;
      cycle();
      sample_now = 1'b0;
      nv = 0;
      for (int k = 0; k < 11; k++) begin
        cycle();
        if (sample_valid) nv++;
      end
      exp_old   = (i == 0) ? tbl[0].exp : tbl[i - 1].exp;
      exp_old_s = (i == 0) ? tbl[0].sign : tbl[i - 1].sign;
      chk("tbl_pulses", nv, 1);
      chk("tbl_valid", sample_valid, 1);
      chk("tbl_cur", cur_d, tbl[i].exp);
      chk("tbl_cur_sign", temp_value_sign, tbl[i].sign);
      chk("tbl_old", old_d, exp_old);
      chk("tbl_old_sign", temp_value_sign_old, exp_old_s);
      if (i == 0) chk("tick_collision_overrun", overrun, 1);
    end

    // Second sample_now at E+5 is dropped and flags overrun.
    do_reset();
    temp_raw = 10'd321; temp_sign = 1'b0; sample_now = 1'b1;
    cycle();
    sample_now = 1'b0;
    nv = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) begin
        temp_raw = 10'd777; temp_sign = 1'b1; sample_now = 1'b1;
      end
      cycle();
      sample_now = 1'b0;
      if (k == 5) chk("overrun_set", overrun, 1);
      if (sample_valid) nv++;
    end
    chk("overrun_pulses", nv, 1);
    chk("overrun_cur", cur_d, 12'h321);
    chk("overrun_sign", temp_value_sign, 0);
    chk("overrun_sticky", overrun, 1);

    // Reset after E+6 aborts the conversion.
    temp_raw = 10'd888; sample_now = 1'b1;
    cycle();
    sample_now = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    do_reset();
    wait_slot(nv);
    chk("abort_no_valid", nv, 0);
    temp_raw = 10'd50; temp_sign = 1'b0; sample_now = 1'b1;
    cycle();
    sample_now = 1'b0;
    for (int k = 0; k < 11; k++) cycle();
    chk("after_abort_valid", sample_valid, 1);
    chk("after_abort_cur", cur_d, 12'h050);
    chk("after_abort_old", old_d, 12'h050);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      temp_raw   = 10'($urandom_range(0, 1023));
      temp_sign  = 1'($urandom_range(0, 1));
      sample_now = ($urandom_range(0, 7) == 0);
      en         = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
